// File: rtl/conv_pkg.sv
// Pixel and window types shared by the window generator and the conv2d stage.
// The window edge and the pixel width must match on both sides of that link.
package conv_pkg;

    localparam int K_SIZE = 3;
    localparam int PIX_W  = 9;

    typedef logic signed [PIX_W-1:0] pixel_t;

    // [r][c]: r=0 is the oldest (top) line, c=0 is the leftmost column.
    typedef pixel_t [0:K_SIZE-1][0:K_SIZE-1] window_t;

endpackage

// File: rtl/window_gen_if.sv
// Pixel-in / window-out stream bundle of the window generator.
// Both sides use valid/ready: a beat moves on a rising clk edge where valid
// and ready are both high; valid must not wait for ready; while valid is high
// and ready is low, the payload (pixel/sof or window/last) stays stable.
interface window_gen_if;
    import conv_pkg::*;

    logic    in_valid;
    logic    in_ready;
    pixel_t  in_pixel;
    logic    in_sof;
    logic    out_valid;
    logic    out_ready;
    window_t out_window;
    logic    out_last;

    modport slave (
        input  in_valid, in_pixel, in_sof, out_ready,
        output in_ready, out_valid, out_window, out_last
    );

    modport master (
        output in_valid, in_pixel, in_sof, out_ready,
        input  in_ready, out_valid, out_window, out_last
    );

endinterface

// File: rtl/window_gen_line_buffer.sv
// One image line of delay: read the old pixel and write the new one at the same
// column address in one cycle. Contents are deliberately not reset.
module line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  pixel_t        wr_data,
    output pixel_t        rd_data
);

    pixel_t mem [DEPTH];

    // Read is combinational so the old value is seen in the same cycle as the write.
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_gen.sv
// Raster-order pixel stream in, KxK sliding window of valid positions out.
// K-1 chained line buffers feed the right column of a KxK window register.
module window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic        clk,
    input  logic        rst,
    window_gen_if.slave bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(K_SIZE - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(K_SIZE - 1);

    logic [CW-1:0] col, col_eff, col_nxt;
    logic [RW-1:0] row, row_eff, row_nxt;
    logic          accept;
    logic          out_valid_q;
    logic          out_last_q;
    window_t       win_q;
    window_t       win_nxt;
    pixel_t        lb_rd [K_SIZE-1];
    pixel_t        lb_wr [K_SIZE-1];

    // Single output register: a new window may enter as the held one leaves.
    assign bus.in_ready   = !out_valid_q || bus.out_ready;
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_window = win_q;

    // A start-of-frame pixel is (0,0) regardless of where the counters stand.
    assign col_eff = bus.in_sof ? '0 : col;
    assign row_eff = bus.in_sof ? '0 : row;

    always_comb begin
        col_nxt = col_eff + 1'b1;
        row_nxt = row_eff;
        if (col_eff == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
        end
    end

    // linebuf[0] holds the previous line; each stage pushes its old pixel deeper.
    for (genvar i = 0; i < K_SIZE - 1; i++) begin : g_lb
        if (i == 0) begin : g_head
            assign lb_wr[i] = bus.in_pixel;
        end else begin : g_tail
            assign lb_wr[i] = lb_rd[i-1];
        end

        line_buffer #(
            .DEPTH (IMG_W),
            .AW    (CW)
        ) u_lb (
            .clk     (clk),
            .wr_en   (accept),
            .addr    (col_eff),
            .wr_data (lb_wr[i]),
            .rd_data (lb_rd[i])
        );
    end

    always_comb begin
        win_nxt = win_q;
        for (int r = 0; r < K_SIZE; r++) begin
            for (int c = 0; c < K_SIZE - 1; c++) begin
                win_nxt[r][c] = win_q[r][c+1];
            end
        end
        for (int r = 0; r < K_SIZE - 1; r++) begin
            win_nxt[r][K_SIZE-1] = lb_rd[K_SIZE-2-r];
        end
        win_nxt[K_SIZE-1][K_SIZE-1] = bus.in_pixel;
    end

    // The window shifts on every accept; it is flagged valid only once it spans
    // K full lines and K columns of the same line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col         <= '0;
            row         <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (accept) begin
            col         <= col_nxt;
            row         <= row_nxt;
            win_q       <= win_nxt;
            out_valid_q <= (row_eff >= ROW_MIN) && (col_eff >= COL_MIN);
            out_last_q  <= (row_eff == ROW_LAST) && (col_eff == COL_LAST);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule
